// File: rtl/rr_arb_pkg.sv
// Shared constants and pointer-width helpers for the round-robin arbiter.
// Optional assertions in the top are enabled by defining RR_ARB_ASSERT_EN.
package rr_arb_pkg;

  localparam int unsigned RR_ARB_N_DEFAULT = 4;

  // Width of a pointer that can index n agents; at least one bit.
  function automatic int unsigned rr_ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [rr_ptr_w(RR_ARB_N_DEFAULT)-1:0] rr_ptr_default_t;

endpackage

// File: rtl/rr_arb_prio_sel.sv
// Combinational circular priority search: finds the first requester at or after ptr.
module rr_arb_prio_sel
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = RR_ARB_N_DEFAULT,
  parameter int unsigned PW = rr_ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [PW-1:0] nxt_ptr_c,
  output logic          any_req_c
);

  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  sel;
  logic [PW-1:0] idx;

  // Upper half (indices >= ptr) searched first, then the unmasked vector as wrap-around.
  always_comb begin
    mask      = '0;
    masked    = '0;
    sel       = '0;
    gnt_c     = '0;
    idx       = '0;
    nxt_ptr_c = '0;
    any_req_c = |req;

    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (PW'(i) >= ptr);
    end
    masked = req & mask;
    sel    = (|masked) ? masked : req;
    gnt_c  = sel & (~sel + N'(1));

    for (int i = 0; i < int'(N); i++) begin
      if (gnt_c[i]) idx = PW'(i);
    end
    nxt_ptr_c = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant and rotating priority pointer.
// Define RR_ARB_ASSERT_EN to include protocol assertions.
module round_robin_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = RR_ARB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = rr_ptr_w(N);

  logic [PW-1:0] ptr;
  logic [N-1:0]  nxt_gnt_c;
  logic [PW-1:0] nxt_ptr_c;
  logic          any_req_c;

  rr_arb_prio_sel #(
    .N  (N),
    .PW (PW)
  ) u_prio_sel (
    .req       (req),
    .ptr       (ptr),
    .gnt_c     (nxt_gnt_c),
    .nxt_ptr_c (nxt_ptr_c),
    .any_req_c (any_req_c)
  );

  // Pointer only advances on an actual grant; idle cycles keep the old priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      ptr <= '0;
    end else begin
      gnt <= nxt_gnt_c;
      if (any_req_c) ptr <= nxt_ptr_c;
    end
  end

`ifdef RR_ARB_ASSERT_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_subset:  assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~$past(req)) == '0);
  a_ptr_range:   assert property (@(posedge clk) disable iff (!rst_n) int'(ptr) < int'(N));
  a_gnt_reset:   assert property (@(posedge clk) !rst_n |-> gnt == '0);
`else
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter with N=4.
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  int         n_tests;
  int         n_fail;

  round_robin_arbiter #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply req for one edge, then check grant and pointer on the following negedge.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                      input logic [1:0] exp_ptr);
    req = r;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, "_ptr"}, 32'(dut.ptr), 32'(exp_ptr));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_ptr", 32'(dut.ptr), 32'h0);
    rst_n = 1'b1;

    step("first",  4'b0001, 4'b0001, 2'd1);
    step("single2", 4'b0100, 4'b0100, 2'd3);

    step("sat0", 4'b1111, 4'b1000, 2'd0);
    step("sat1", 4'b1111, 4'b0001, 2'd1);
    step("sat2", 4'b1111, 4'b0010, 2'd2);
    step("sat3", 4'b1111, 4'b0100, 2'd3);
    step("sat4", 4'b1111, 4'b1000, 2'd0);

    step("setp2", 4'b0010, 4'b0010, 2'd2);
    step("p2_a",  4'b0011, 4'b0001, 2'd1);
    step("p2_b",  4'b0011, 4'b0010, 2'd2);

    step("idle0", 4'b0000, 4'b0000, 2'd2);
    step("idle1", 4'b0000, 4'b0000, 2'd2);
    step("idle2", 4'b0000, 4'b0000, 2'd2);
    step("resume0", 4'b1111, 4'b0100, 2'd3);
    step("resume1", 4'b1111, 4'b1000, 2'd0);

    step("lone0", 4'b0100, 4'b0100, 2'd3);
    step("lone1", 4'b0100, 4'b0100, 2'd3);
    step("lone2", 4'b0100, 4'b0100, 2'd3);
    step("drop",  4'b0000, 4'b0000, 2'd3);

    step("pre0", 4'b1111, 4'b1000, 2'd0);
    step("pre1", 4'b1111, 4'b0001, 2'd1);
    @(posedge clk);
    #1;
    check_eq("pre2_gnt", 32'(gnt), 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_gnt", 32'(gnt), 32'h0);
    check_eq("async_ptr", 32'(dut.ptr), 32'h0);
    @(negedge clk);
    check_eq("hold_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    step("post0", 4'b1111, 4'b0001, 2'd1);
    step("post1", 4'b1111, 4'b0010, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The module SHALL have a parameter N, default 4, giving the number of requesters (N >= 2).
REQ-002 The module SHALL have an input port clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have an input port rst_n, 1 bit, the asynchronous active-low reset.
REQ-004 The module SHALL have an input port req, N bits, where bit i set means agent i requests.
REQ-005 The module SHALL have an output port gnt, N bits, the registered grant, which is one-hot or zero.

Function
REQ-006 Each rising clk edge SHALL re-arbitrate, with gnt registered and valid one cycle after req is sampled.
REQ-007 A priority pointer ptr (range 0..N-1) SHALL select the highest-priority index, with priority descending circularly ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-008 The next gnt SHALL be the one-hot bit of the first set req bit in that circular order.
REQ-009 If req is all zeros, the next gnt SHALL be all zeros and ptr SHALL be unchanged.
REQ-010 On a grant to index k, ptr SHALL become (k+1) mod N, wrapping from N-1 to 0.
REQ-011 A grant SHALL last one cycle only, with no holding or locking; a continuously requesting agent waits for its turn.
REQ-012 Under saturation (all req set), grants SHALL rotate strictly k, k+1, ... mod N, one per cycle.
REQ-013 With a single requester, that requester SHALL be granted every cycle regardless of ptr.
REQ-014 A request deasserted before the sampling edge SHALL not be granted, and gnt SHALL drop to zero in that cycle if no other requests are present.
REQ-015 gnt SHALL never have more than one bit set (onehot0).
REQ-016 Starvation SHALL be bounded: a held request is granted within N cycles.

Reset
REQ-017 While rst_n is low, gnt SHALL be 0 and ptr SHALL be 0 (agent 0 highest priority), asynchronously.
REQ-018 Reset asserted mid-operation SHALL abort the current grant immediately, and the first arbitration after release SHALL use ptr = 0.
REQ-019 Deassertion of rst_n SHALL take effect at the first rising clk edge at which rst_n is sampled high.

Configuration
REQ-020 When macro RR_ARB_ASSERT_EN is defined, the design SHALL include concurrent assertions that gnt is onehot0, that gnt is a subset of the req sampled the previous cycle, that ptr < N, and that gnt is 0 in reset.
REQ-021 Without RR_ARB_ASSERT_EN, the design SHALL contain no assertion code, and its functional behaviour SHALL be identical.

Structure
REQ-022 A shared package rr_arb_pkg SHALL hold the default N constant (RR_ARB_N_DEFAULT = 4) and the pointer-width function/typedef (clog2-based).
REQ-023 A combinational sub-module rr_arb_prio_sel SHALL compute the next grant from req and ptr, using a masked/unmasked (double-width) priority search.
REQ-024 The top module SHALL hold only the gnt and ptr registers plus the sub-module instance.

Verification (N=4)
REQ-025 Reset, then req=0001 for one cycle: gnt SHALL be 0001 and ptr SHALL become 1.
REQ-026 Next, req=0100: gnt SHALL be 0100 and ptr SHALL become 3.
REQ-027 Next, req=1111 held: gnt SHALL be 1000, 0001, 0010, 0100, 1000 on successive cycles.
REQ-028 With ptr=2 and req=0011, gnt SHALL be 0001; if the following cycle has req=0011, gnt SHALL be 0010.
REQ-029 With req=0000 for 3 cycles, gnt SHALL be 0000 with ptr unchanged, and then req=1111 SHALL resume the rotation from the old ptr.
REQ-030 Asserting rst_n=0 during saturation SHALL set gnt to 0000 without waiting for a clock edge, and after release req=1111 SHALL grant 0001 first.
